fe_mem_responder: RTL and testbench

Synthesizable bus responder (slave) terminating the accelerator front-end memory interface (`acc_valid/acc_addr/acc_wdata/acc_wstrb` in, `acc_ready/acc_rdata/acc_rvalid` out). It holds a word-addressed on-chip RAM, executes byte-strobed writes and fixed-latency reads, and serves one transaction at a time. It also provides a debug port for preloading and inspecting the RAM. It replaces behavioural memory models behind `int_sum_v2` and later accelerators.

---
 rtl/fe_mem_responder.sv | 125 ++++++++++++
 tb/tb_fe_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_mem_responder.sv
// Bus responder for the accelerator front-end memory interface: word-addressed RAM with
// byte-strobed writes, fixed-latency reads, sticky range error and an IDLE-only debug port.
module fe_mem_responder #(
   parameter int                ADDR_W      = 22,
   parameter int                DATA_W      = 32,
   parameter int                DEPTH_WORDS = 1024,
   parameter int                READ_LAT    = 2,
   parameter logic [DATA_W-1:0] DEAD_WORD   = 32'hDEADBEEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           acc_valid,
   input  logic [ADDR_W-1:0]              acc_addr,
   input  logic [DATA_W-1:0]              acc_wdata,
   input  logic [DATA_W/8-1:0]            acc_wstrb,
   output logic                           acc_ready,
   output logic [DATA_W-1:0]              acc_rdata,
   output logic                           acc_rvalid,
   output logic                           err,
   input  logic                           err_clr,
   input  logic                           dbg_en,
   input  logic                           dbg_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
   input  logic [DATA_W-1:0]              dbg_wdata,
   output logic [DATA_W-1:0]              dbg_rdata,
   output logic                           dbg_ready
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int NB = DATA_W / 8;
   localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WACK, RWAIT, RDATA} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic              rd_first;
   logic [AW-1:0]     rd_idx;
   logic              rd_oor;
   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   logic [ADDR_W-3:0] widx;
   logic              in_range;
   logic              is_wr;
   logic              accept;
   logic              dbg_act;
   logic              unused_addr_lsbs;

   assign widx             = acc_addr[ADDR_W-1:2];
   assign in_range         = (widx < DEPTH_LIM);
   assign is_wr            = |acc_wstrb;
   assign accept           = (state == IDLE) && acc_valid && !dbg_en;
   assign dbg_act          = (state == IDLE) && dbg_en;
   assign unused_addr_lsbs = ^acc_addr[1:0];

   // NOTE: always_comb gives every output a default first so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      acc_ready  = 1'b0;
      acc_rvalid = 1'b0;
      dbg_ready  = 1'b0;
      case (state)
         IDLE: begin
            dbg_ready = 1'b1;
            if (accept) state_nxt = is_wr ? WACK : RWAIT;
         end
         WACK: begin
            acc_ready = 1'b1;
            state_nxt = IDLE;
         end
         RWAIT: begin
            acc_ready = rd_first;
            if (cnt == 4'd0) state_nxt = RDATA;
         end
         RDATA: begin
            acc_rvalid = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rd_first  <= 1'b0;
         rd_idx    <= '0;
         rd_oor    <= 1'b0;
         acc_rdata <= '0;
         err       <= 1'b0;
         dbg_rdata <= '0;
      end else begin
         state    <= state_nxt;
         rd_first <= accept && !is_wr;

         if (accept && !is_wr) begin
            rd_idx <= widx[AW-1:0];
            rd_oor <= !in_range;
            cnt    <= 4'(READ_LAT);
         end else if (state == RWAIT) begin
            if (cnt == 4'd0) acc_rdata <= rd_oor ? DEAD_WORD : mem[rd_idx];
            else             cnt       <= cnt - 4'd1;
         end

         // A new error at the same edge as err_clr takes priority.
         if (accept && !in_range) err <= 1'b1;
         else if (err_clr)        err <= 1'b0;

         if (dbg_act && !dbg_we) dbg_rdata <= mem[dbg_addr];
      end
   end

   // NOTE: the RAM array has no reset; contents survive rst_n and power up undefined.
   always_ff @(posedge clk) begin
      if (rst_n && accept && is_wr && in_range) begin
         for (int b = 0; b < NB; b++)
            if (acc_wstrb[b]) mem[widx[AW-1:0]][8*b +: 8] <= acc_wdata[8*b +: 8];
      end else if (rst_n && dbg_act && dbg_we) begin
         mem[dbg_addr] <= dbg_wdata;
      end
   end

endmodule

// File: tb/tb_fe_mem_responder.sv
// Scoreboard bench for fe_mem_responder: directed bus/debug traffic, read responses checked
// by a negedge monitor against expected data and arrival cycle.
module tb_fe_mem_responder;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        acc_valid, acc_ready, acc_rvalid, err, err_clr;
   logic [21:0] acc_addr;
   logic [31:0] acc_wdata, acc_rdata, dbg_wdata, dbg_rdata;
   logic [3:0]  acc_wstrb;
   logic        dbg_en, dbg_we, dbg_ready;
   logic [9:0]  dbg_addr;

   // second instance with zero read latency
   logic        v0, ready0, rvalid0, err0, dbg_ready0;
   logic [31:0] rdata0, dbg_rdata0;
   logic        dbg_en0 = 1'b0;

   always #5 clk = ~clk;

   fe_mem_responder #(.READ_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .acc_valid(acc_valid), .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_wstrb(acc_wstrb),
      .acc_ready(acc_ready), .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid),
      .err(err), .err_clr(err_clr),
      .dbg_en(dbg_en), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready)
   );

   fe_mem_responder #(.READ_LAT(0)) u_lat0 (
      .clk(clk), .rst_n(rst_n),
      .acc_valid(v0), .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_wstrb(acc_wstrb),
      .acc_ready(ready0), .acc_rdata(rdata0), .acc_rvalid(rvalid0),
      .err(err0), .err_clr(1'b0),
      .dbg_en(dbg_en0), .dbg_we(1'b0), .dbg_addr(10'd0), .dbg_wdata(32'd0),
      .dbg_rdata(dbg_rdata0), .dbg_ready(dbg_ready0)
   );

   typedef struct {
      logic [31:0] data;
      int          due;
   } rexp_t;

   rexp_t       rq[$];
   logic [31:0] dq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic        dbg_rd_seen = 1'b0;
   logic        prev_ready = 1'b0;
   rexp_t       mon_e;
   logic [31:0] mon_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      dbg_rd_seen <= rst_n && dbg_en && !dbg_we && dbg_ready;
   end

   // Monitor: compares whatever the DUT presents against the queued expectations.
   always @(negedge clk) begin
      if (acc_rvalid) begin
         if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected actual=1 expected=0 (t=%0t)", $time);
         end else begin
            mon_e = rq.pop_front();
            check("acc_rdata", acc_rdata, mon_e.data);
            check("rvalid_cycle", cyc, mon_e.due);
         end
      end
      if (dbg_rd_seen) begin
         if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dbg_read_unexpected (t=%0t)", $time);
         end else begin
            mon_d = dq.pop_front();
            check("dbg_rdata", dbg_rdata, mon_d);
         end
      end
      if (acc_ready) check("ready_single_pulse", prev_ready, 1'b0);
      prev_ready = acc_ready;
   end

   task automatic dbg_write(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      dbg_en = 1'b1; dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
      @(negedge clk);
      dbg_en = 1'b0; dbg_we = 1'b0;
   endtask

   task automatic dbg_read(input logic [9:0] a, input logic [31:0] exp);
      @(negedge clk);
      dbg_en = 1'b1; dbg_we = 1'b0; dbg_addr = a;
      dq.push_back(exp);
      @(negedge clk);
      dbg_en = 1'b0;
   endtask

   // One bus transaction. hold>0 keeps a debug access active for that many cycles first.
   task automatic bus(input logic [21:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input logic [31:0] exp, input bit push, input bit clr, input int hold,
                      output int lat);
      bit got;
      int w;
      @(negedge clk);
      acc_addr = a; acc_wdata = wd; acc_wstrb = st; acc_valid = 1'b1; err_clr = clr;
      if (hold > 0) begin
         dbg_en = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd200; dbg_wdata = 32'd0;
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         if (acc_ready) got = 1'b1;
         else if (lat == hold) begin
            dbg_en = 1'b0; dbg_we = 1'b0;
         end
      end
      if (got && push && st == 4'd0) rq.push_back('{data: exp, due: cyc + LAT + 1});
      acc_valid = 1'b0; acc_wstrb = 4'd0; err_clr = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout addr=%h", a);
      end
      w = 0;
      while (push && rq.size() > 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (rq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL rvalid_timeout addr=%h pending=%0d", a, rq.size());
         rq.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},     acc_ready,  1'b0);
      check({tag, "_rvalid"},    acc_rvalid, 1'b0);
      check({tag, "_rdata"},     acc_rdata,  32'd0);
      check({tag, "_err"},       err,        1'b0);
      check({tag, "_dbg_rdata"}, dbg_rdata,  32'd0);
      check({tag, "_dbg_ready"}, dbg_ready,  1'b1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int lat;
      rst_n = 1'b0;
      acc_valid = 1'b0; acc_addr = '0; acc_wdata = '0; acc_wstrb = '0; err_clr = 1'b0;
      dbg_en = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; v0 = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Preload words 0..15 with their index, word 64 with a known pattern.
      for (int i = 0; i < 16; i++) dbg_write(10'(i), 32'(i));
      dbg_write(10'd64, 32'h11223344);

      // Read byte address 0x1C -> word 7.
      bus(22'h1C, 32'd0, 4'd0, 32'h7, 1'b1, 1'b0, 0, lat);
      check("read_ready_latency", lat, 1);

      // Partial write of lanes 0 and 2.
      bus(22'h100, 32'hAABBCCDD, 4'b0101, 32'd0, 1'b1, 1'b0, 0, lat);
      check("write_ready_latency", lat, 1);
      dbg_read(10'd64, 32'h11BB33DD);
      bus(22'h100, 32'd0, 4'd0, 32'h11BB33DD, 1'b1, 1'b0, 0, lat);

      // Summation traffic: read 0..7 and 8..15, write the sums to words 64 and 65.
      for (int i = 0; i < 8; i++) bus(22'(4 * i), 32'd0, 4'd0, 32'(i), 1'b1, 1'b0, 0, lat);
      bus(22'h100, 32'h1C, 4'hF, 32'd0, 1'b1, 1'b0, 0, lat);
      for (int i = 8; i < 16; i++) bus(22'(4 * i), 32'd0, 4'd0, 32'(i), 1'b1, 1'b0, 0, lat);
      bus(22'h104, 32'h5C, 4'hF, 32'd0, 1'b1, 1'b0, 0, lat);
      check("b2b_write_latency", lat, 1);
      dbg_read(10'd64, 32'h1C);
      dbg_read(10'd65, 32'h5C);

      // Debug access blocks acceptance for 4 cycles.
      bus(22'h14, 32'd0, 4'd0, 32'h5, 1'b1, 1'b0, 4, lat);
      check("dbg_block_latency", lat, 5);

      // Out-of-range read, then out-of-range write coinciding with err_clr.
      bus(22'h1000, 32'd0, 4'd0, 32'hDEADBEEF, 1'b1, 1'b0, 0, lat);
      check("oor_read_err", err, 1'b1);
      bus(22'h1000, 32'h55555555, 4'hF, 32'd0, 1'b1, 1'b1, 0, lat);
      check("oor_set_beats_clr", err, 1'b1);
      dbg_read(10'd0, 32'd0);
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      check("err_clr", err, 1'b0);
      bus(22'h3FFFFC, 32'd0, 4'd0, 32'hDEADBEEF, 1'b1, 1'b0, 0, lat);
      check("oor_top_err", err, 1'b1);

      // Reset during RWAIT: no response may follow.
      bus(22'h1C, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 0, lat);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midread_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      bus(22'h1C, 32'd0, 4'd0, 32'h7, 1'b1, 1'b0, 0, lat);
      check("post_reset_latency", lat, 1);

      // Zero-latency instance: write then read word 3.
      @(negedge clk);
      acc_addr = 22'h0C; acc_wdata = 32'hCAFEF00D; acc_wstrb = 4'hF; v0 = 1'b1;
      @(negedge clk);
      check("lat0_write_ready", ready0, 1'b1);
      v0 = 1'b0; acc_wstrb = 4'd0;
      @(negedge clk);
      v0 = 1'b1;
      @(negedge clk);
      check("lat0_read_ready", ready0, 1'b1);
      v0 = 1'b0;
      @(negedge clk);
      check("lat0_rvalid", rvalid0, 1'b1);
      check("lat0_rdata", rdata0, 32'hCAFEF00D);

      repeat (6) @(negedge clk);
      check("scoreboard_empty", 32'(rq.size() + dq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
